// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop rx sync, mid-bit sampling on baud_tick, parity/frame checks,
// single-word valid/ready holding register that drops new frames (flagging overrun) while stalled.
module uart_rx_os #(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] HALF      = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL      = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s;
  logic [TW-1:0]         tick_cnt, tick_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  perr, perr_nxt;
  logic                  ferr, ferr_nxt;
  logic                  mid;
  logic                  done;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      perr     <= perr_nxt;
      ferr     <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    done      = 1'b0;
    // Past the start bit, every OVERSAMPLE-th tick lands mid-bit.
    mid       = baud_tick && (tick_cnt == FULL);
    if (baud_tick && !mid) tick_nxt = tick_cnt + TW'(1);
    case (state)
      IDLE: begin
        tick_nxt = '0;
        if (baud_tick && !rx_s) begin
          state_nxt = START;
          bit_nxt   = '0;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
        end
      end
      START: begin
        if (baud_tick && tick_cnt == HALF) begin
          tick_nxt  = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (mid) begin
          tick_nxt  = '0;
          shift_nxt = {rx_s, shift[DATA_WIDTH-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (mid) begin
          tick_nxt  = '0;
          perr_nxt  = (PARITY_MODE == 2) ? (^shift ^ rx_s) : ~(^shift ^ rx_s);
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (mid) begin
          tick_nxt = '0;
          if (!rx_s) ferr_nxt = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            bit_nxt   = '0;
            done      = 1'b1;
            state_nxt = rx_s ? IDLE : WAIT_IDLE;
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end
      end
      WAIT_IDLE: begin
        tick_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completing frame wins over the handshake clear; if the held word is stalled it is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done && (!out_valid || out_ready)) begin
      out_data   <= shift;
      out_valid  <= 1'b1;
      parity_err <= perr;
      frame_err  <= ferr_nxt;
      overrun    <= 1'b0;
    end else if (done) begin
      overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
